// File: rtl/constants_pipe.sv
// Pipelined constant-operand datapath (merge / add+offset / xor-key / accumulate)
// with a valid/ready output stage. Define CONST_PIPE_SAT_EN for saturating add/acc and sticky ovf.
module constants_pipe #(
  parameter int          WIDTH  = 32,
  parameter int          STAGES = 2,
  parameter logic [31:0] MASK   = 32'h0000FFFF,
  parameter logic [31:0] OFFSET = 32'h00000001,
  parameter logic [31:0] KEY    = 32'hA5A5A5A5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MASK_W   = WIDTH'(MASK);
  localparam logic [WIDTH-1:0] OFFSET_W = WIDTH'(OFFSET);
  localparam logic [WIDTH-1:0] KEY_W    = WIDTH'(KEY);

  logic [WIDTH-1:0] data_q [STAGES];
  logic [WIDTH-1:0] data_d [STAGES];
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             stall, accept;
  logic [WIDTH-1:0] acc_base, add_res, acc_res, res_d;
  logic             add_ovf, acc_ovf, sat_hit;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  // A clear coinciding with a mode-3 accept acts as if applied before the add.
  assign acc_base = acc_clr ? '0 : acc_q;

`ifdef CONST_PIPE_SAT_EN
  logic [WIDTH+1:0] add_sum;
  logic [WIDTH:0]   acc_sum;
  assign add_sum = {2'b00, a} + {2'b00, b} + {2'b00, OFFSET_W};
  assign acc_sum = {1'b0, acc_base} + {1'b0, a};
  assign add_ovf = |add_sum[WIDTH+1:WIDTH];
  assign acc_ovf = acc_sum[WIDTH];
  assign add_res = add_ovf ? '1 : add_sum[WIDTH-1:0];
  assign acc_res = acc_ovf ? '1 : acc_sum[WIDTH-1:0];
`else
  assign add_ovf = 1'b0;
  assign acc_ovf = 1'b0;
  assign add_res = a + b + OFFSET_W;
  assign acc_res = acc_base + a;
`endif

  always_comb begin
    res_d   = '0;
    sat_hit = 1'b0;
    case (mode)
      2'd0: res_d = (a & MASK_W) | (b & ~MASK_W);
      2'd1: begin
        res_d   = add_res;
        sat_hit = add_ovf;
      end
      2'd2: res_d = a ^ KEY_W;
      default: begin
        res_d   = acc_res;
        sat_hit = acc_ovf;
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (accept && mode == 2'd3) acc_d = acc_res;
    else if (acc_clr)           acc_d = '0;
  end

  assign ovf_d = ovf_q | (accept & sat_hit);

  // Single global stall: every stage holds while the output beat is refused.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < STAGES; i++) data_d[i] = data_q[i];
    if (!stall) begin
      vld_d[0] = accept;
      if (accept) data_d[0] = res_d;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign y         = data_q[STAGES-1];
  assign out_valid = vld_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_constants_pipe.sv
// Randomised + directed bench for constants_pipe against an arithmetic reference model.
// Honours CONST_PIPE_SAT_EN the same way as the design.
module tb_constants_pipe;

  localparam logic [31:0] MASK   = 32'h0000FFFF;
  localparam logic [31:0] OFFSET = 32'h00000001;
  localparam logic [31:0] KEY    = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, y;
  logic [1:0]  mode;
  logic        in_valid, in_ready, acc_clr, out_valid, out_ready, ovf;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc_m;
  logic        ovf_m;

  constants_pipe #(.WIDTH(32), .STAGES(2), .MASK(MASK), .OFFSET(OFFSET), .KEY(KEY)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .acc_clr(acc_clr),
    .y(y), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Saturating/wrapping sum of two 32-bit values, plain integer arithmetic.
  function automatic logic [31:0] fold(input longint unsigned s, output logic sat);
    logic [63:0] t;
    t   = s;
    sat = 1'b0;
    if (s > 64'h00000000FFFFFFFF) begin
`ifdef CONST_PIPE_SAT_EN
      sat = 1'b1;
      return 32'hFFFFFFFF;
`else
      return t[31:0];
`endif
    end
    return t[31:0];
  endfunction

  // Reference model: observe handshakes half a cycle before the edge that commits them.
  always @(negedge clk) begin
    logic [31:0]     r, base;
    logic            sat;
    longint unsigned s;
    if (rst) begin
      exp_q.delete();
      acc_m = 32'h0;
      ovf_m = 1'b0;
    end else begin
      chk("ovf", ovf, ovf_m);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stale_out", out_valid, 1'b0);
        else begin
          chk("y", y, exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        sat = 1'b0;
        case (mode)
          2'd0: r = (a & MASK) | (b & ~MASK);
          2'd1: begin
            s = longint'(a) + longint'(b) + longint'(OFFSET);
            r = fold(s, sat);
          end
          2'd2: r = a ^ KEY;
          default: begin
            base  = acc_clr ? 32'h0 : acc_m;
            s     = longint'(base) + longint'(a);
            r     = fold(s, sat);
            acc_m = r;
          end
        endcase
        if (sat) ovf_m = 1'b1;
        exp_q.push_back(r);
        if (acc_clr && mode != 2'd3) acc_m = 32'h0;
      end else if (acc_clr) begin
        acc_m = 32'h0;
      end
    end
  end

  initial begin
    logic [31:0] vals [6];
    logic [31:0] y_hold;
    logic        took;
    int          i, t, out0;

    rst = 1'b1; a = '0; b = '0; mode = '0; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y, 32'h0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_ir", in_ready, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    cyc();

    // mode 0 latency and single-cycle valid
    in_valid = 1'b1; mode = 2'd0; a = 32'h12345678; b = 32'hABCDEF01;
    cyc();
    in_valid = 1'b0;
    chk("m0_early", out_valid, 1'b0);
    cyc();
    chk("m0_y", y, 32'hABCD5678);
    chk("m0_ov", out_valid, 1'b1);
    cyc();
    chk("m0_ov_drop", out_valid, 1'b0);

    // mode 1 normal and overflow
    in_valid = 1'b1; mode = 2'd1; a = 32'h00001000; b = 32'h10000000;
    cyc();
    a = 32'hFFFFFFFF; b = 32'h00000001;
    cyc();
    in_valid = 1'b0;
    chk("m1_y", y, 32'h10001001);
    cyc();
`ifdef CONST_PIPE_SAT_EN
    chk("m1_sat_y", y, 32'hFFFFFFFF);
    chk("m1_sat_ovf", ovf, 1'b1);
`else
    chk("m1_wrap_y", y, 32'h00000001);
    chk("m1_wrap_ovf", ovf, 1'b0);
`endif
    cyc();

    // mode 2 xor key
    in_valid = 1'b1; mode = 2'd2; a = 32'h0; b = 32'hFFFFFFFF;
    cyc();
    a = 32'hA5A5A5A5;
    cyc();
    in_valid = 1'b0;
    chk("m2_y0", y, 32'hA5A5A5A5);
    cyc();
    chk("m2_y1", y, 32'h0);
    cyc();

    // mode 3 accumulate, then clear-with-accept
    in_valid = 1'b1; mode = 2'd3; a = 32'h1;
    cyc();
    a = 32'h1000;
    cyc();
    chk("m3_y0", y, 32'h1);
    a = 32'h10000000;
    cyc();
    chk("m3_y1", y, 32'h1001);
    a = 32'h5; acc_clr = 1'b1;
    cyc();
    chk("m3_y2", y, 32'h10001001);
    in_valid = 1'b0; acc_clr = 1'b0;
    cyc();
    chk("m3_clr", y, 32'h5);
    cyc();

    // six mode-2 beats with a three-cycle stall in the middle
    for (int k = 0; k < 6; k++) vals[k] = $urandom;
    out0 = n_out; i = 0; t = 0; y_hold = '0;
    while (i < 6 && t < 50) begin
      out_ready = !(t >= 3 && t < 6);
      in_valid = 1'b1; mode = 2'd2; a = vals[i]; b = $urandom;
      #1;
      if (t >= 3 && t < 6) begin
        chk("stall_ir", in_ready, 1'b0);
        if (t == 3) y_hold = y;
        else chk("stall_y", y, y_hold);
      end
      took = in_ready;
      cyc();
      if (took) i++;
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("stall_cnt", n_out - out0, 6);

    // randomised traffic
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      mode      = 2'($urandom_range(0, 3));
      a         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      b         = $urandom;
      acc_clr   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("drain", exp_q.size(), 0);

    // reset with beats in flight
    in_valid = 1'b1; mode = 2'd1; a = 32'hFFFFFFFF; b = 32'h10;
    repeat (2) cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_y", y, 32'h0);
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_ir", in_ready, 1'b1);
    chk("mid_rst_ovf", ovf, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("post_rst_ov", out_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
